// File: rtl/pwm_ramp_ctrl_if.sv
// Ramp-request handshake between a sequencer (master) and pwm_ramp_ctrl (slave).
// Carries the target duty, step size and inter-step rate with a valid/ready pair.
interface pwm_ramp_ctrl_if #(
  parameter int RATE_W = 8
);
  logic              tgt_valid;
  logic              tgt_ready;
  logic [9:0]        tgt_duty;
  logic [3:0]        tgt_step;
  logic [RATE_W-1:0] tgt_rate;

  modport master (
    output tgt_valid,
    output tgt_duty,
    output tgt_step,
    output tgt_rate,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    input  tgt_step,
    input  tgt_rate,
    output tgt_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller: walks duty_cycle toward a requested target in
// fixed steps, updating only at PWM period boundaries so no period is split.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | holding duty_cycle, ready for a new ramp request
// RAMP  | stepping duty_cycle toward target every rate+1 periods
module pwm_ramp_ctrl #(
  parameter int RATE_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_ramp_ctrl_if.slave tgt,
  input  logic          stop,
  output logic [9:0]    duty_cycle,
  output logic          period_tick,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [9:0]        phase;
  logic [9:0]        target;
  logic [3:0]        step;
  logic [RATE_W-1:0] rate;
  logic [RATE_W-1:0] rate_cnt;
  logic [10:0]       sum_up;
  logic [9:0]        next_duty;

  assign period_tick   = (phase == 10'd1023);
  assign tgt.tgt_ready = (state == IDLE) && !stop;
  assign busy          = (state == RAMP);

  // Upward sum is 11 bits so duty near full scale clamps instead of wrapping.
  always_comb begin
    sum_up    = {1'b0, duty_cycle} + {7'b0, step};
    next_duty = duty_cycle;
    if (duty_cycle < target) begin
      next_duty = (sum_up > {1'b0, target}) ? target : sum_up[9:0];
    end else if (duty_cycle > target) begin
      next_duty = ((duty_cycle - target) <= {6'b0, step}) ? target
                                                          : (duty_cycle - {6'b0, step});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= 10'd0;
      duty_cycle <= 10'd0;
      rate_cnt   <= '0;
      rate       <= '0;
      target     <= 10'd0;
      step       <= 4'd1;
      state      <= IDLE;
      done       <= 1'b0;
    end else begin
      phase <= phase + 10'd1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt.tgt_valid && tgt.tgt_ready) begin
            target   <= tgt.tgt_duty;
            step     <= (tgt.tgt_step == 4'd0) ? 4'd1 : tgt.tgt_step;
            rate     <= tgt.tgt_rate;
            rate_cnt <= '0;
            if (tgt.tgt_duty == duty_cycle) begin
              done <= 1'b1;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          // stop outranks a coincident period boundary: no step is applied.
          if (stop) begin
            state <= IDLE;
          end else if (period_tick) begin
            if (rate_cnt < rate) begin
              rate_cnt <= rate_cnt + RATE_ONE;
            end else begin
              rate_cnt   <= '0;
              duty_cycle <= next_duty;
              if (next_duty == target) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: table of ramp requests with a queue of
// expected duty steps, plus directed stop / reset / zero-step sequences.
module tb_pwm_ramp_ctrl;

  localparam int RATE_W = 8;

  logic       clk;
  logic       rst_n;
  logic       stop;
  logic [9:0] duty_cycle;
  logic       period_tick;
  logic       busy;
  logic       done;

  pwm_ramp_ctrl_if #(.RATE_W(RATE_W)) tgt_if ();

  pwm_ramp_ctrl #(.RATE_W(RATE_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tgt         (tgt_if),
    .stop        (stop),
    .duty_cycle  (duty_cycle),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    int step;
    int rate;
    int n_steps;
    int fin;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp;
  int   n_err;
  int   mdl_duty;
  int   exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (period_tick !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    if (period_tick !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no period_tick within 1100 cycles", name);
    end
  endtask

  task automatic send_req(input int t, input int s, input int r, input logic with_stop);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_duty  = 10'(t);
    tgt_if.tgt_step  = 4'(s);
    tgt_if.tgt_rate  = RATE_W'(r);
    stop             = with_stop;
  endtask

  task automatic clear_req();
    tgt_if.tgt_valid = 1'b0;
    stop             = 1'b0;
  endtask

  // Expected duty sequence from the clamped min/max stepping rule.
  task automatic push_expected(input int t, input int s);
    int d;
    int se;
    se = (s == 0) ? 1 : s;
    d  = mdl_duty;
    while (d != t) begin
      if (d < t) d = (d + se > t) ? t : d + se;
      else       d = (d - se < t) ? t : d - se;
      exp_q.push_back(d);
    end
  endtask

  task automatic run_ramp(input vec_t v);
    int prev;
    int exp_d;
    push_expected(v.tgt, v.step);
    check("ready_before_req", int'(tgt_if.tgt_ready), 1);
    send_req(v.tgt, v.step, v.rate, 1'b0);
    @(negedge clk);
    clear_req();
    if (v.tgt == mdl_duty) begin
      check("eq_done_pulse", int'(done), 1);
      check("eq_busy", int'(busy), 0);
      @(negedge clk);
      check("eq_done_clear", int'(done), 0);
      check("eq_busy_after", int'(busy), 0);
    end else begin
      check("busy_after_accept", int'(busy), 1);
      prev = mdl_duty;
      for (int k = 0; k < v.n_steps; k++) begin
        for (int p = 0; p <= v.rate; p++) begin
          wait_tick("ramp_tick");
          check("duty_held_in_tick", int'(duty_cycle), prev);
          @(negedge clk);
          if (p < v.rate) check("duty_held_rate_wait", int'(duty_cycle), prev);
        end
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : v.fin;
        check("duty_step", int'(duty_cycle), exp_d);
        if (k == v.n_steps - 1) begin
          check("final_duty", int'(duty_cycle), v.fin);
          check("final_done", int'(done), 1);
          check("final_busy", int'(busy), 0);
          @(negedge clk);
          check("done_one_cycle", int'(done), 0);
        end else begin
          check("mid_done", int'(done), 0);
          check("mid_busy", int'(busy), 1);
        end
        prev = exp_d;
      end
    end
    exp_q.delete();
    mdl_duty = v.fin;
  endtask

  initial begin
    int   cnt;
    logic saw_done;

    vecs[0] = '{tgt: 100,  step: 10, rate: 0, n_steps: 10, fin: 100};
    vecs[1] = '{tgt: 95,   step: 15, rate: 2, n_steps: 1,  fin: 95};
    vecs[2] = '{tgt: 1020, step: 15, rate: 0, n_steps: 62, fin: 1020};
    vecs[3] = '{tgt: 1023, step: 15, rate: 0, n_steps: 1,  fin: 1023};
    vecs[4] = '{tgt: 1023, step: 5,  rate: 0, n_steps: 0,  fin: 1023};

    n_cmp    = 0;
    n_err    = 0;
    mdl_duty = 0;
    rst_n    = 1'b0;
    stop     = 1'b0;
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_duty  = 10'd0;
    tgt_if.tgt_step  = 4'd0;
    tgt_if.tgt_rate  = '0;

    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty_cycle), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    check("post_rst_ready", int'(tgt_if.tgt_ready), 1);
    check("post_rst_tick", int'(period_tick), 0);

    foreach (vecs[i]) run_ramp(vecs[i]);

    // Reset mid-ramp: ramp abandoned, no done, phase restarts.
    send_req(0, 15, 0, 1'b0);
    @(negedge clk);
    clear_req();
    check("rr_busy_before", int'(busy), 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rr_duty", int'(duty_cycle), 0);
    check("rr_busy", int'(busy), 0);
    check("rr_done", int'(done), 0);
    check("rr_ready", int'(tgt_if.tgt_ready), 1);
    check("rr_tick0", int'(period_tick), 0);
    cnt      = 0;
    saw_done = 1'b0;
    while (period_tick !== 1'b1 && cnt < 1100) begin
      @(negedge clk);
      cnt++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("rr_tick_latency", cnt, 1023);
    check("rr_no_done", int'(saw_done), 0);
    @(negedge clk);
    mdl_duty = 0;

    // Stop coincident with period_tick at duty 40; same-cycle request rejected.
    send_req(100, 10, 0, 1'b0);
    @(negedge clk);
    clear_req();
    for (int k = 1; k <= 4; k++) begin
      wait_tick("stop_ramp_tick");
      @(negedge clk);
      check("stop_ramp_duty", int'(duty_cycle), 10 * k);
    end
    wait_tick("stop_tick");
    send_req(500, 3, 0, 1'b1);
    check("stop_ready_low", int'(tgt_if.tgt_ready), 0);
    @(negedge clk);
    clear_req();
    check("stop_duty_held", int'(duty_cycle), 40);
    check("stop_busy", int'(busy), 0);
    check("stop_done", int'(done), 0);
    @(negedge clk);
    check("stop_req_rejected_busy", int'(busy), 0);
    check("stop_req_rejected_duty", int'(duty_cycle), 40);

    // Zero step acts as one.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_duty = 0;
    run_ramp('{tgt: 3, step: 0, rate: 0, n_steps: 3, fin: 3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
